extend_scheduler: RTL
=====================

Name: extend_scheduler

Overview:
- Shares one registered immediate-extension unit between two requesters:
  - A: instruction decode.
  - B: UART program loader / debug path.
- Each requester supplies a 16-bit immediate and an extension mode.
- The block arbitrates between them, sequences the extension unit, and returns the 32-bit result with a per-requester completion pulse.
- Sits between decode/UART control and the ALU operand mux.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin between A and B; 1 = A always wins a tie.

Ports:
- clock    in   1   system clock, rising edge
- reset    in   1   asynchronous, active-low; 0 clears all state
- enable   in   1   global advance; 0 freezes the FSM and arbitration state
- req_a    in   1   requester A request; held with operands until gnt_a
- imm_a    in   16  requester A immediate
- mode_a   in   2   requester A mode: 00 zero, 01 sign, 10 upper (imm<<16), 11 reserved
- req_b    in   1   requester B request
- imm_b    in   16  requester B immediate
- mode_b   in   2   requester B mode
- gnt_a    out  1   one-cycle pulse: A's operands accepted
- gnt_b    out  1   one-cycle pulse: B's operands accepted
- done_a   out  1   one-cycle pulse: result valid for A
- done_b   out  1   one-cycle pulse: result valid for B
- result   out  32  last extended value; held until the next done
- busy     out  1   1 when the FSM is not IDLE

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE.
  - gnt_a, gnt_b, done_a, done_b, busy = 0.
  - result = 32'h0.
  - Operand, mode and owner registers = 0.
  - last_owner = B, so A wins the first tie.
- FSM states: IDLE, EXTEND. All transitions occur only on rising edges with enable=1.
- IDLE:
  - No req: stay in IDLE.
  - At least one req: select the winner, latch its imm, mode and owner; pulse the matching gnt; go to EXTEND.
- EXTEND:
  - Extension unit enabled for one edge.
  - On that edge: result <= extended value, pulse the owner's done, go to IDLE.
- Latency:
  - Request seen at edge N → gnt high after edge N.
  - done and result valid after edge N+1.
  - Throughput: 1 op per 2 enabled cycles.
- Arbitration:
  - Single request: it wins.
  - Both requests, FIXED_PRIORITY=0: the requester not equal to last_owner wins; last_owner updates on every grant.
  - Both requests, FIXED_PRIORITY=1: A wins.
  - The loser keeps its req high and is granted in the next IDLE cycle.
- Extension rules, 16→32:
  - 00 → {16'h0, imm}
  - 01 → {{16{imm[15]}}, imm}
  - 10 → {imm, 16'h0}
  - 11 → treated as 00 (zero-extend)
- Handshake:
  - The requester drops req in the cycle it sees gnt.
  - A req still high when the FSM next samples in IDLE is a new, back-to-back transaction. This is legal and starts a second operation.
- Pulses:
  - gnt and done are single-cycle registered pulses.
  - They clear on the next rising edge regardless of enable; a pulse is never stretched.
- enable=0:
  - State, operands, last_owner and result are held.
  - No new grants or completions occur.
  - An in-flight EXTEND completes on the first enabled edge.
- busy = (state != IDLE), registered with the state.
- Reset mid-operation: the in-flight transaction is dropped, no done is issued, and requesters must re-request.
- Req during EXTEND: ignored until IDLE; no grant is issued while busy.

Decomposition:
- Shared package: mode encodings (MODE_ZERO=2'b00, MODE_SIGN=2'b01, MODE_UPPER=2'b10); FSM state encodings; owner encoding (OWNER_A, OWNER_B).
- Sub-module ext_unit:
  - Registered 16→32 extender with clock, reset (active-low async), enable, imm, mode, extended output.
  - Three modes.
  - Holds its output when enable=0.
  - result is driven directly from it.
- Arbitration and FSM stay in extend_scheduler.

Test Plan:
- Reset: assert reset=0 mid-EXTEND with req_a=1 → all outputs 0; no done_a; first grant after release goes to A.
- Single A, sign mode: req_a=1, imm_a=16'h8001, mode_a=01 → gnt_a pulse after edge N; done_a after N+1; result=32'hFFFF8001; done_b stays 0.
- Modes on B:
  - imm_b=16'h8001, mode 00 → 32'h00008001.
  - mode 10 → 32'h80010000.
  - mode 11 → 32'h00008001.
- Contention, round-robin: req_a and req_b held high, imm_a=16'h0001, imm_b=16'h0002, mode 00 → grants alternate A,B,A,B; results 1,2,1,2; one done per 2 cycles.
- FIXED_PRIORITY=1, both reqs held → only A granted while req_a=1; B granted the cycle after req_a drops.
- Freeze: enable=0 for 5 cycles during EXTEND → result, busy=1 and state held; gnt/done pulses last exactly one cycle; done issued on the first enabled edge.

Source files
------------

// File: rtl/extend_scheduler_pkg.sv
// Shared encodings for the immediate-extension scheduler: operand modes,
// FSM states, requester ownership, and the 16->32 extension rule itself.
package extend_scheduler_pkg;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_EXTEND  = 1'b1;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Reserved mode 2'b11 falls through to zero-extension.
    function automatic logic [31:0] extend16(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] val;
        case (mode)
            MODE_SIGN:  val = {{16{imm[15]}}, imm};
            MODE_UPPER: val = {imm, 16'h0000};
            default:    val = {16'h0000, imm};
        endcase
        return val;
    endfunction

endpackage

// File: rtl/extend_scheduler_ext_unit.sv
// Registered 16->32 immediate extender shared by both requesters.
// Latency: 1 enabled edge. Backpressure: none; output holds while enable=0.
// Output register clears on reset and is the scheduler's result directly.
module ext_unit
    import extend_scheduler_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] imm,
    input  logic [1:0]  mode,
    output logic [31:0] extended
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            extended <= 32'h0;
        end else if (enable) begin
            extended <= extend16(imm, mode);
        end
    end

endmodule

// File: rtl/extend_scheduler.sv
// Arbitrates requesters A/B onto one registered immediate extender.
// Latency: gnt 1 edge after request, done/result 1 edge after gnt; 1 op per 2 cycles.
// Backpressure: requests hold until gnt; enable=0 freezes state, pulses still clear.
module extend_scheduler
    import extend_scheduler_pkg::*;
#(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        req_a,
    input  logic [15:0] imm_a,
    input  logic [1:0]  mode_a,
    input  logic        req_b,
    input  logic [15:0] imm_b,
    input  logic [1:0]  mode_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic [31:0] result,
    output logic        busy
);

    logic [0:0]  state;
    logic [15:0] op_imm;
    logic [1:0]  op_mode;
    logic        owner;
    logic        last_owner;
    logic        win_owner;
    logic        ext_en;

    // On a tie, round-robin hands the grant to whoever did not win last time.
    always_comb begin
        win_owner = OWNER_A;
        if (req_a && req_b) begin
            if (FIXED_PRIORITY != 0) begin
                win_owner = OWNER_A;
            end else begin
                win_owner = (last_owner == OWNER_A) ? OWNER_B : OWNER_A;
            end
        end else if (req_b) begin
            win_owner = OWNER_B;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_imm     <= 16'h0;
            op_mode    <= MODE_ZERO;
            owner      <= OWNER_A;
            last_owner <= OWNER_B;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            done_a     <= 1'b0;
            done_b     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Pulses drop on every edge so a frozen cycle never stretches them.
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            if (enable) begin
                case (state)
                    ST_IDLE: begin
                        if (req_a || req_b) begin
                            op_imm     <= (win_owner == OWNER_A) ? imm_a : imm_b;
                            op_mode    <= (win_owner == OWNER_A) ? mode_a : mode_b;
                            owner      <= win_owner;
                            last_owner <= win_owner;
                            gnt_a      <= (win_owner == OWNER_A);
                            gnt_b      <= (win_owner == OWNER_B);
                            state      <= ST_EXTEND;
                            busy       <= 1'b1;
                        end
                    end
                    default: begin
                        done_a <= (owner == OWNER_A);
                        done_b <= (owner == OWNER_B);
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ext_en = enable && (state == ST_EXTEND);

    ext_unit u_ext (
        .clock    (clock),
        .reset    (reset),
        .enable   (ext_en),
        .imm      (op_imm),
        .mode     (op_mode),
        .extended (result)
    );

endmodule
